// File: rtl/axis_skid_buffer.sv
// ---------------------------------------------------------------------------
// axis_skid_buffer
// Two-entry AXI-Stream register slice. Every output (write_tready,
// read_tvalid, read_tdata, count) comes straight from a flop, so no input
// reaches an output combinationally. While the output register is busy, a
// second beat can land in the skid register. This keeps full throughput even
// though write_tready is registered.
//
// Ports
//   clk           : clock, all logic on the rising edge
//   reset         : synchronous active-high reset
//   write_tdata_* : upstream beat (write_tdata, write_tvalid, write_tready)
//   read_tdata_*  : downstream beat (read_tdata, read_tvalid, read_tready)
//   count         : occupancy, 0..2 beats
// ---------------------------------------------------------------------------
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] write_tdata,
  input  logic                  write_tvalid,
  output logic                  write_tready,
  output logic [DATA_WIDTH-1:0] read_tdata,
  output logic                  read_tvalid,
  input  logic                  read_tready,
  output logic [1:0]            count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] out_q,   out_d;
  logic [DATA_WIDTH-1:0] skid_q,  skid_d;
  logic                  wready_q, wready_d;
  logic                  rvalid_q, rvalid_d;
  logic [1:0]            count_q,  count_d;

  logic wr_xfer;
  logic rd_xfer;

  assign wr_xfer = write_tvalid & wready_q;
  assign rd_xfer = rvalid_q & read_tready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (wr_xfer) begin
          out_d   = write_tdata;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (wr_xfer && rd_xfer) begin
          out_d = write_tdata;
        end else if (wr_xfer) begin
          skid_d  = write_tdata;
          state_d = FULL;
        end else if (rd_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (rd_xfer) begin
          out_d   = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Handshake and occupancy flops are loaded from the next state.
    // This way they always agree with state_q after the edge and still
    // appear at the outputs as pure register values.
    wready_d = (state_d != FULL);
    rvalid_d = (state_d != EMPTY);
    case (state_d)
      EMPTY:   count_d = 2'd0;
      BUSY:    count_d = 2'd1;
      FULL:    count_d = 2'd2;
      default: count_d = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= EMPTY;
      out_q    <= '0;
      skid_q   <= '0;
      wready_q <= 1'b0;
      rvalid_q <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      skid_q   <= skid_d;
      wready_q <= wready_d;
      rvalid_q <= rvalid_d;
      count_q  <= count_d;
    end
  end

  assign write_tready = wready_q;
  assign read_tvalid  = rvalid_q;
  assign read_tdata   = out_q;
  assign count        = count_q;

endmodule

// File: tb/tb_axis_skid_buffer.sv
module tb_axis_skid_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] write_tdata;
  logic       write_tvalid;
  logic       write_tready;
  logic [7:0] read_tdata;
  logic       read_tvalid;
  logic       read_tready;
  logic [1:0] count;

  axis_skid_buffer #(.DATA_WIDTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .write_tdata  (write_tdata),
    .write_tvalid (write_tvalid),
    .write_tready (write_tready),
    .read_tdata   (read_tdata),
    .read_tvalid  (read_tvalid),
    .read_tready  (read_tready),
    .count        (count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: a FIFO of at most two beats plus the registered
  // handshake view the downstream side should see after each edge.
  logic [7:0] mq[$];
  logic       m_wready = 1'b0;
  logic       m_zero   = 1'b1;   // data output known to be zero (after reset)

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_wready"}, 32'(write_tready), 32'(m_wready));
    check_eq({tag, "_rvalid"}, 32'(read_tvalid), 32'(mq.size() != 0));
    check_eq({tag, "_count"},  32'(count), 32'(mq.size()));
    if (mq.size() != 0)
      check_eq({tag, "_rdata"}, 32'(read_tdata), 32'(mq[0]));
    else if (m_zero)
      check_eq({tag, "_rdata0"}, 32'(read_tdata), 32'h0);
  endtask

  // Drive one cycle: the inputs are applied here, the edge happens, and then
  // the model advances. Outputs are checked on the following falling edge.
  task automatic step(input logic rst, input logic wv, input logic [7:0] wd,
                      input logic rr, input string tag);
    logic wr, rd;
    reset        = rst;
    write_tvalid = wv;
    write_tdata  = wd;
    read_tready  = rr;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_wready = 1'b0;
      m_zero   = 1'b1;
    end else begin
      wr = wv && m_wready;
      rd = rr && (mq.size() != 0);
      if (rd) void'(mq.pop_front());
      if (wr) begin
        mq.push_back(wd);
        m_zero = 1'b0;
      end
      m_wready = (mq.size() < 2);
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  logic [7:0] stim[256];
  logic [7:0] recv[$];

  initial begin
    reset = 1'b1; write_tvalid = 1'b0; write_tdata = '0; read_tready = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0, "rst");
    step(1'b1, 1'b1, 8'h77, 1'b1, "rst_hs");
    step(1'b0, 1'b0, 8'h00, 1'b0, "rel");
    check_eq("rel_wready_hi", 32'(write_tready), 32'h1);

    // Pass-through: 0x01..0x20 with read_tready held high.
    for (int i = 1; i <= 32; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b1, "pt");
      check_eq("pt_first_lat", 32'(read_tdata), 32'(i));
      check_eq("pt_count_le1", 32'(count <= 2'd1), 32'h1);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, "pt_end");

    // Fill, then attempt a third beat.
    step(1'b0, 1'b1, 8'hA5, 1'b0, "fill1");
    step(1'b0, 1'b1, 8'h5A, 1'b0, "fill2");
    check_eq("fill_count", 32'(count), 32'h2);
    check_eq("fill_wready", 32'(write_tready), 32'h0);
    check_eq("fill_data", 32'(read_tdata), 32'hA5);
    step(1'b0, 1'b1, 8'hFF, 1'b0, "fill3");
    check_eq("fill3_count", 32'(count), 32'h2);

    // Drain from FULL.
    step(1'b0, 1'b0, 8'h00, 1'b1, "drain1");
    check_eq("drain1_data", 32'(read_tdata), 32'h5A);
    check_eq("drain1_wready", 32'(write_tready), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b1, "drain2");
    check_eq("drain2_rvalid", 32'(read_tvalid), 32'h0);
    check_eq("drain2_count", 32'(count), 32'h0);

    // Simultaneous read and write in BUSY.
    step(1'b0, 1'b1, 8'h11, 1'b0, "sim_load");
    step(1'b0, 1'b1, 8'h22, 1'b1, "sim_rw");
    check_eq("sim_data", 32'(read_tdata), 32'h22);
    check_eq("sim_count", 32'(count), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b1, "sim_end");

    // Reset mid-stream from FULL.
    step(1'b0, 1'b1, 8'h33, 1'b0, "mr_f1");
    step(1'b0, 1'b1, 8'h44, 1'b0, "mr_f2");
    step(1'b1, 1'b1, 8'h55, 1'b1, "mr_rst");
    check_eq("mr_rdata", 32'(read_tdata), 32'h0);
    check_eq("mr_wready", 32'(write_tready), 32'h0);
    step(1'b0, 1'b0, 8'h00, 1'b1, "mr_rel");
    check_eq("mr_rel_wready", 32'(write_tready), 32'h1);
    step(1'b0, 1'b0, 8'h00, 1'b1, "mr_nostale");
    check_eq("mr_nostale_rvalid", 32'(read_tvalid), 32'h0);

    // Random backpressure soak.
    for (int i = 0; i < 256; i++) stim[i] = 8'($urandom);
    begin
      int unsigned idx = 0;
      int unsigned cyc = 0;
      logic wv, rr;
      while (recv.size() < 256 && cyc < 4000) begin
        wv = (idx < 256) && ($urandom_range(0, 1) == 1);
        rr = ($urandom_range(0, 1) == 1);
        if (read_tvalid && rr) recv.push_back(read_tdata);
        if (wv && m_wready) begin
          step(1'b0, 1'b1, stim[idx], rr, "soak");
          idx++;
        end else begin
          step(1'b0, wv, (idx < 256) ? stim[idx] : 8'h00, rr, "soak");
        end
        cyc++;
      end
      check_eq("soak_len", 32'(recv.size()), 32'd256);
      for (int i = 0; i < 256 && i < recv.size(); i++)
        check_eq("soak_data", 32'(recv[i]), 32'(stim[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_skid_buffer.md
AXIS_SKID_BUFFER -- requirements
Module: axis_skid_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the tdata width in bits of both stream ports.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset sampled on the rising edge of clk.
REQ-004 SHALL have port write_tdata, input, DATA_WIDTH, the slave-side data from the upstream master.
REQ-005 SHALL have port write_tvalid, input, 1, upstream data valid.
REQ-006 SHALL have port write_tready, output, 1, buffer can accept a beat.
REQ-007 SHALL have port read_tdata, output, DATA_WIDTH, the master-side data to the downstream slave.
REQ-008 SHALL have port read_tvalid, output, 1, read_tdata valid.
REQ-009 SHALL have port read_tready, input, 1, downstream accepts a beat.
REQ-010 SHALL have port count, output, 2, current occupancy of 0, 1 or 2 beats.

Function
REQ-011 SHALL define a write transfer as write_tvalid & write_tready high at a rising edge, and a read transfer as read_tvalid & read_tready high at a rising edge.
REQ-012 SHALL drive write_tready, read_tvalid, read_tdata and count directly from registers, with no combinational path from any input to any output.
REQ-013 SHALL implement three states: EMPTY (count 0), BUSY (count 1, beat in output register), FULL (count 2, beats in output and skid registers).
REQ-014 SHALL in EMPTY: on write, load write_tdata into the output register and go to BUSY; otherwise stay.
REQ-015 SHALL in BUSY with write only: store write_tdata in the skid register, go to FULL and deassert write_tready.
REQ-016 SHALL in BUSY with read only: go to EMPTY and deassert read_tvalid.
REQ-017 SHALL in BUSY with simultaneous read and write: load write_tdata into the output register and stay in BUSY.
REQ-018 SHALL in FULL: hold write_tready low; on read, move the skid register into the output register, go to BUSY and reassert write_tready; otherwise hold.
REQ-019 SHALL assert write_tready exactly in EMPTY and BUSY after reset release, and read_tvalid exactly in BUSY and FULL.
REQ-020 SHALL give a latency of 1 cycle: a beat written at edge N appears on read_tdata with read_tvalid high after edge N.
REQ-021 SHALL sustain one beat per cycle when read_tready is held high, with no bubbles.
REQ-022 SHALL preserve beat order, never drop or duplicate a beat, and keep read_tdata stable while read_tvalid is high and read_tready is low.
REQ-023 SHALL ignore write_tdata and write_tvalid while write_tready is low.

Reset
REQ-024 SHALL while reset is high at an edge force EMPTY, count 0, read_tvalid 0, read_tdata 0, skid register 0 and write_tready 0.
REQ-025 SHALL raise write_tready on the first rising edge at which reset is sampled low.
REQ-026 SHALL on reset mid-operation, in any state, discard all buffered beats, and SHALL NOT count a handshake in the reset cycle as a transfer.

Verification
REQ-027 SHALL cover pass-through: reset; stream 0x01..0x20 with read_tready=1 -> output 0x01..0x20 in order, one per cycle, first beat 1 cycle after its write, count never exceeds 1.
REQ-028 SHALL cover fill: read_tready=0; write 0xA5 then 0x5A -> count=2, write_tready=0, read_tdata=0xA5; a third beat 0xFF is held off, not accepted.
REQ-029 SHALL cover drain from FULL: from REQ-028 state, read_tready=1 for 2 cycles -> read 0xA5 then 0x5A, then read_tvalid=0 and count=0; write_tready=1 after the first read.
REQ-030 SHALL cover a random backpressure soak: 256 random bytes with random write_tvalid and read_tready at 50% -> response equals stimulus exactly and read_tdata is stable under stall.
REQ-031 SHALL cover simultaneous transfer in BUSY: holding 0x11, write 0x22 with read_tready=1 in the same cycle -> 0x11 read, read_tdata=0x22 next cycle, count stays 1.
REQ-032 SHALL cover reset mid-stream: in FULL, assert reset for 1 cycle -> next cycle count=0, read_tvalid=0, read_tdata=0, write_tready=0; one cycle after release write_tready=1 and no stale beat appears.
